// File: rtl/reg_wb_pkg.sv
// Shared types and constants for the register-file writeback buffer.
// Entry fields are sized by the package defaults below.
package reg_wb_pkg;

  localparam int WB_DATA_W = 16;
  localparam int WB_ADDR_W = 1;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  // Pointer width for a power-of-two queue depth (>= 2).
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/reg_wb_fwd_match.sv
// Priority address match over queue entries ordered youngest-first.
// The lowest index holding a valid match wins.
module reg_wb_fwd_match
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_entry_t             i_entries [DEPTH],
  input  logic [DEPTH-1:0]      i_valid,
  input  logic [WB_ADDR_W-1:0]  i_addr,
  output logic                  o_hit,
  output logic [WB_DATA_W-1:0]  o_data
);

  // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    // Walk oldest to youngest so the youngest match overwrites earlier ones.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (i_valid[i] && (i_entries[i].addr == i_addr)) begin
        o_hit  = 1'b1;
        o_data = i_entries[i].data;
      end
    end
  end

endmodule

// File: rtl/reg_wb_buffer.sv
// In-order writeback FIFO feeding a 1R1W register file, with forwarding lookup.
// Optional feature: define WB_BUF_COALESCE_EN to merge same-address pushes into the youngest entry.
module reg_wb_buffer
  import reg_wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       res_valid_in,
  output logic                       res_ready_out,
  input  logic [ADDR_W-1:0]          res_addr_in,
  input  logic [DATA_W-1:0]          res_data_in,
  input  logic                       drain_en_in,
  output logic                       wen_out,
  output logic [ADDR_W-1:0]          waddr_out,
  output logic [DATA_W-1:0]          wdata_out,
  input  logic [ADDR_W-1:0]          fwd_addr_in,
  output logic                       fwd_hit_out,
  output logic [DATA_W-1:0]          fwd_data_out,
  output logic [$clog2(DEPTH):0]     count_out
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t         r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_wen;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_push;
  logic              w_pop;
  logic              w_coalesce;
  logic              w_alloc;
  wb_entry_t         w_yf_entries [DEPTH];
  logic [DEPTH-1:0]  w_yf_valid;
  logic              w_q_hit;
  logic [DATA_W-1:0] w_q_data;
  logic              w_out_hit;

  // Ready depends only on occupancy, never on the drain enable.
  assign res_ready_out = (r_count != CW'(DEPTH));
  assign w_push        = res_valid_in && res_ready_out;
  assign w_pop         = drain_en_in && (r_count != '0);

`ifdef WB_BUF_COALESCE_EN
  logic [PW-1:0] w_youngest;
  assign w_youngest = r_wr_ptr - PW'(1);
  // A lone entry leaving this cycle cannot absorb the push.
  assign w_coalesce = w_push && (r_count != '0)
                   && (r_mem[w_youngest].addr == res_addr_in)
                   && !(w_pop && (r_count == CW'(1)));
`else
  assign w_coalesce = 1'b0;
`endif

  assign w_alloc = w_push && !w_coalesce;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_wen    <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else begin
      if (w_alloc) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
        r_wen    <= 1'b1;
        r_waddr  <= r_mem[r_rd_ptr].addr;
        r_wdata  <= r_mem[r_rd_ptr].data;
      end else begin
        r_wen    <= 1'b0;
      end
      r_count <= r_count + CW'(w_alloc) - CW'(w_pop);
    end
  end

  // NOTE: entry storage has no reset; occupancy alone decides which entries are live.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (w_alloc) r_mem[r_wr_ptr] <= '{addr: res_addr_in, data: res_data_in};
`ifdef WB_BUF_COALESCE_EN
      if (w_coalesce) r_mem[w_youngest].data <= res_data_in;
`endif
    end
  end

  // Reorder the ring youngest-first and mark the slots that lie within the occupancy.
  always_comb begin
    w_yf_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_yf_entries[i] = r_mem[r_wr_ptr - PW'(i + 1)];
      w_yf_valid[i]   = (CW'(i) < r_count);
    end
  end

  reg_wb_fwd_match #(
    .DEPTH (DEPTH)
  ) u_fwd_match (
    .i_entries (w_yf_entries),
    .i_valid   (w_yf_valid),
    .i_addr    (fwd_addr_in),
    .o_hit     (w_q_hit),
    .o_data    (w_q_data)
  );

  // The value in flight to the register file is older than anything still queued.
  assign w_out_hit    = r_wen && (r_waddr == fwd_addr_in);
  assign fwd_hit_out  = w_q_hit || w_out_hit;
  assign fwd_data_out = w_q_hit ? w_q_data : (w_out_hit ? r_wdata : '0);

  assign wen_out   = r_wen;
  assign waddr_out = r_waddr;
  assign wdata_out = r_wdata;
  assign count_out = r_count;

endmodule

// File: tb/tb_reg_wb_buffer.sv
// Directed bench for reg_wb_buffer: queue-based reference model checked every cycle,
// plus hand-computed expectations. Honours WB_BUF_COALESCE_EN when defined.
module tb_reg_wb_buffer;

  localparam int DEPTH = 4;
`ifdef WB_BUF_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        res_valid_in;
  logic        res_ready_out;
  logic [0:0]  res_addr_in;
  logic [15:0] res_data_in;
  logic        drain_en_in;
  logic        wen_out;
  logic [0:0]  waddr_out;
  logic [15:0] wdata_out;
  logic [0:0]  fwd_addr_in;
  logic        fwd_hit_out;
  logic [15:0] fwd_data_out;
  logic [2:0]  count_out;

  reg_wb_buffer #(.DATA_W(16), .ADDR_W(1), .DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .res_valid_in  (res_valid_in),
    .res_ready_out (res_ready_out),
    .res_addr_in   (res_addr_in),
    .res_data_in   (res_data_in),
    .drain_en_in   (drain_en_in),
    .wen_out       (wen_out),
    .waddr_out     (waddr_out),
    .wdata_out     (wdata_out),
    .fwd_addr_in   (fwd_addr_in),
    .fwd_hit_out   (fwd_hit_out),
    .fwd_data_out  (fwd_data_out),
    .count_out     (count_out)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending results as a queue plus the register-file write pulse.
  typedef struct {
    int addr;
    int data;
  } ent_t;

  ent_t q[$];
  bit   m_wen;
  int   m_waddr;
  int   m_wdata;
  int   mn;
  bit   m_push, m_pop, m_coal;

  initial begin
    forever begin
      @(posedge clock);
      if (reset) begin
        q.delete();
        m_wen   = 1'b0;
        m_waddr = 0;
        m_wdata = 0;
      end else begin
        mn     = q.size();
        m_push = res_valid_in && (mn != DEPTH);
        m_pop  = drain_en_in && (mn != 0);
        m_coal = COAL && m_push && (mn >= 1) && (q[mn-1].addr == int'(res_addr_in))
                 && !(m_pop && mn == 1);
        if (m_coal) q[mn-1].data = int'(res_data_in);
        if (m_pop) begin
          m_wen   = 1'b1;
          m_waddr = q[0].addr;
          m_wdata = q[0].data;
          void'(q.pop_front());
        end else begin
          m_wen = 1'b0;
        end
        if (m_push && !m_coal) q.push_back('{int'(res_addr_in), int'(res_data_in)});
      end
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  bit e_hit;
  int e_data;
  initial begin
    forever begin
      @(negedge clock);
      if (cmp_en) begin
        e_hit  = 1'b0;
        e_data = 0;
        for (int i = q.size() - 1; i >= 0; i--) begin
          if (q[i].addr == int'(fwd_addr_in)) begin
            e_hit  = 1'b1;
            e_data = q[i].data;
            break;
          end
        end
        if (!e_hit && m_wen && (m_waddr == int'(fwd_addr_in))) begin
          e_hit  = 1'b1;
          e_data = m_wdata;
        end
        check("mdl_count", 32'(count_out), 32'(q.size()));
        check("mdl_ready", 32'(res_ready_out), 32'(q.size() != DEPTH));
        check("mdl_wen",   32'(wen_out), 32'(m_wen));
        if (m_wen) begin
          check("mdl_waddr", 32'(waddr_out), 32'(m_waddr));
          check("mdl_wdata", 32'(wdata_out), 32'(m_wdata));
        end
        check("mdl_fwd_hit",  32'(fwd_hit_out), 32'(e_hit));
        check("mdl_fwd_data", 32'(fwd_data_out), 32'(e_data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drain_empty();
    valid_off();
    drain_en_in = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (count_out == 0) break;
      cyc();
    end
    check("drain_empty", 32'(count_out), 32'd0);
    cyc();
  endtask

  task automatic valid_off();
    res_valid_in = 1'b0;
  endtask

  task automatic push_set(input int a, input int d);
    res_valid_in = 1'b1;
    res_addr_in  = 1'(a);
    res_data_in  = 16'(d);
  endtask

  initial begin
    reset        = 1'b1;
    res_valid_in = 1'b0;
    res_addr_in  = '0;
    res_data_in  = '0;
    drain_en_in  = 1'b0;
    fwd_addr_in  = '0;
    repeat (2) cyc();
    reset = 1'b0;
    #1;
    check("rst_wen",   32'(wen_out), 32'd0);
    check("rst_waddr", 32'(waddr_out), 32'd0);
    check("rst_wdata", 32'(wdata_out), 32'd0);
    check("rst_count", 32'(count_out), 32'd0);
    check("rst_ready", 32'(res_ready_out), 32'd1);
    cmp_en = 1'b1;

    // Single result: accept edge, pop edge, one-cycle write pulse.
    push_set(1, 16'hBEEF);
    drain_en_in = 1'b1;
    cyc();
    valid_off();
    #1;
    check("t1_wen_after_accept", 32'(wen_out), 32'd0);
    check("t1_count_after_accept", 32'(count_out), 32'd1);
    cyc(); #1;
    check("t1_wen", 32'(wen_out), 32'd1);
    check("t1_waddr", 32'(waddr_out), 32'd1);
    check("t1_wdata", 32'(wdata_out), 32'hBEEF);
    cyc(); #1;
    check("t1_wen_drop", 32'(wen_out), 32'd0);
    check("t1_wdata_hold", 32'(wdata_out), 32'hBEEF);

    // Fill with drain stalled, refuse a fifth, then drain in order.
    drain_en_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_set(i % 2, 16'hA000 + i);
      cyc();
    end
    #1;
    check("t2_count_full", 32'(count_out), 32'd4);
    check("t2_ready_full", 32'(res_ready_out), 32'd0);
    push_set(0, 16'h5555);
    cyc(); #1;
    check("t2_fifth_refused", 32'(count_out), 32'd4);
    valid_off();
    drain_en_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      check("t2_drain_wen", 32'(wen_out), 32'd1);
      check("t2_drain_data", 32'(wdata_out), 32'hA000 + 32'(i));
    end
    cyc(); #1;
    check("t2_idle_wen", 32'(wen_out), 32'd0);

    // Full buffer with push+pop, then push+pop at count 3, then wrapping traffic.
    drain_en_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_set(i % 2, 16'hB000 + i);
      cyc();
    end
    push_set(0, 16'hBBBB);
    drain_en_in = 1'b1;
    cyc(); #1;
    check("t3_full_pushpop_count", 32'(count_out), 32'd3);
    check("t3_full_pushpop_data", 32'(wdata_out), 32'hB000);
    push_set(0, 16'hCCCC);
    cyc(); #1;
    check("t3_pushpop_count", 32'(count_out), 32'd3);
    check("t3_pushpop_data", 32'(wdata_out), 32'hB001);
    for (int i = 0; i < 20; i++) begin
      res_valid_in = (i % 3) != 0;
      drain_en_in  = (i % 4) != 1;
      res_addr_in  = 1'((i / 2) % 2);
      res_data_in  = 16'hD000 + 16'(i);
      fwd_addr_in  = 1'(i % 2);
      cyc();
    end
    drain_empty();

    // Forwarding returns the youngest pending value, then nothing once retired.
    drain_en_in = 1'b0;
    push_set(0, 16'h1111);
    cyc();
    push_set(0, 16'h2222);
    cyc();
    valid_off();
    fwd_addr_in = 1'b0;
    #1;
    check("t4_fwd_hit", 32'(fwd_hit_out), 32'd1);
    check("t4_fwd_data", 32'(fwd_data_out), 32'h2222);
    fwd_addr_in = 1'b1;
    #1;
    check("t4_fwd_miss_hit", 32'(fwd_hit_out), 32'd0);
    check("t4_fwd_miss_data", 32'(fwd_data_out), 32'd0);
    fwd_addr_in = 1'b0;
    drain_en_in = 1'b1;
    cyc(); #1;
    check("t4_fwd_draining", 32'(fwd_data_out), 32'h2222);
    cyc();
    cyc(); #1;
    check("t4_fwd_gone_hit", 32'(fwd_hit_out), 32'd0);
    check("t4_fwd_gone_data", 32'(fwd_data_out), 32'd0);

    // Reset mid-stream drops queued results.
    drain_en_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_set(i % 2, 16'hE000 + i);
      cyc();
    end
    valid_off();
    #1;
    check("t5_count_before", 32'(count_out), 32'd3);
    reset       = 1'b1;
    drain_en_in = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    check("t5_wen_after_rst", 32'(wen_out), 32'd0);
    check("t5_count_after_rst", 32'(count_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      check("t5_no_write", 32'(wen_out), 32'd0);
    end

    // Two same-address pushes with drain stalled.
    drain_en_in = 1'b0;
    push_set(1, 16'h0001);
    cyc();
    push_set(1, 16'h0002);
    cyc();
    valid_off();
    #1;
    check("t6_count", 32'(count_out), COAL ? 32'd1 : 32'd2);
    drain_en_in = 1'b1;
    cyc(); #1;
    check("t6_first_wen", 32'(wen_out), 32'd1);
    check("t6_first_data", 32'(wdata_out), COAL ? 32'h0002 : 32'h0001);
    cyc(); #1;
    check("t6_second_wen", 32'(wen_out), COAL ? 32'd0 : 32'd1);
    check("t6_second_data", 32'(wdata_out), 32'h0002);
    drain_empty();

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
